// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch PC unit.
//   state_t    - fetch sequencer states
//   PC_W       - program counter width
//   INSTR_W    - instruction word width
//   ALIGN_BITS - low PC bits that must be zero for a legal fetch target
package fetch_pkg;

    localparam int PC_W       = 64;
    localparam int INSTR_W    = 32;
    localparam int ALIGN_BITS = 2;

    typedef enum logic [2:0] {
        RST,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    // A target is legal only when it lands on an instruction-word boundary.
    function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
        return pc[ALIGN_BITS-1:0] == '0;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, loads RESET_PC
//   load - capture d on the next edge
//   d    - new PC value
//   q    - current PC
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= RESET_PC;
        else if (load) q <= d;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register plus instruction-fetch sequencer.
//   CLK, Reset            - clock, asynchronous active-high reset
//   NextPC, AdvancePC     - next target from upstream, qualified by AdvancePC
//   CurrentPC             - PC of the instruction being fetched/held
//   IMemReq, IMemAddr     - fetch request and address (held until granted)
//   IMemGnt               - memory accepted the request
//   IMemRdValid/RdData    - returned instruction word
//   Instruction/InstrValid- latched instruction for decode
//   FetchFault            - sticky misaligned-target fault
//   RetireCount           - accepted AdvancePC events, wraps at 2^CNT_W
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0,
    parameter int              CNT_W    = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [PC_W-1:0]    NextPC,
    input  logic               AdvancePC,
    output logic [PC_W-1:0]    CurrentPC,
    output logic               IMemReq,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic               IMemGnt,
    input  logic               IMemRdValid,
    input  logic [INSTR_W-1:0] IMemRdData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic               FetchFault,
    output logic [CNT_W-1:0]   RetireCount
);

    state_t state, next_state;
    logic   pc_load;
    logic   latch;
    logic   retire;
    logic   fault_set;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (CLK),
        .rst  (Reset),
        .load (pc_load),
        .d    (NextPC),
        .q    (CurrentPC)
    );

    // The request address is simply the PC; it stays put until the PC is
    // reloaded, which only happens from HOLD.
    assign IMemAddr = CurrentPC;

    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        latch      = 1'b0;
        retire     = 1'b0;
        fault_set  = 1'b0;
        case (state)
            RST: next_state = REQ;
            REQ: begin
                // Zero-wait memories may grant and return in one cycle.
                if (IMemGnt && IMemRdValid) begin
                    latch      = 1'b1;
                    next_state = HOLD;
                end else if (IMemGnt) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (IMemRdValid) begin
                    latch      = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (AdvancePC) begin
                    // The faulting advance still retires the held instruction.
                    retire = 1'b1;
                    if (pc_aligned(NextPC)) begin
                        pc_load    = 1'b1;
                        next_state = REQ;
                    end else begin
                        fault_set  = 1'b1;
                        next_state = FAULT;
                    end
                end
            end
            FAULT: next_state = FAULT;
            default: next_state = RST;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= RST;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b0;
            Instruction <= '0;
            FetchFault  <= 1'b0;
            RetireCount <= '0;
        end else begin
            state      <= next_state;
            IMemReq    <= (next_state == REQ);
            InstrValid <= (next_state == HOLD);
            if (latch)     Instruction <= IMemRdData;
            if (fault_set) FetchFault  <= 1'b1;
            if (retire)    RetireCount <= RetireCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset;
    logic [63:0] NextPC;
    logic        AdvancePC, IMemGnt, IMemRdValid;
    logic [31:0] IMemRdData;

    logic [63:0] CurrentPC, IMemAddr;
    logic        IMemReq, InstrValid, FetchFault;
    logic [31:0] Instruction, RetireCount;

    // Second instance with a 4-bit counter; it sees identical inputs, so its
    // sequencing matches the main instance and only the counter width differs.
    logic [63:0] pc4, addr4;
    logic        req4, ivld4, fault4;
    logic [31:0] ins4;
    logic [3:0]  cnt4;

    fetch_pc_unit #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .AdvancePC(AdvancePC),
        .CurrentPC(CurrentPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemGnt(IMemGnt), .IMemRdValid(IMemRdValid), .IMemRdData(IMemRdData),
        .Instruction(Instruction), .InstrValid(InstrValid),
        .FetchFault(FetchFault), .RetireCount(RetireCount)
    );

    fetch_pc_unit #(.RESET_PC(64'h0), .CNT_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .AdvancePC(AdvancePC),
        .CurrentPC(pc4), .IMemReq(req4), .IMemAddr(addr4),
        .IMemGnt(IMemGnt), .IMemRdValid(IMemRdValid), .IMemRdData(IMemRdData),
        .Instruction(ins4), .InstrValid(ivld4),
        .FetchFault(fault4), .RetireCount(cnt4)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_pc;
    int          m_cnt;
    logic [31:0] last_ins;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Serve one fetch: gd cycles before grant, response rd cycles after the
    // grant cycle (rd=0 means same cycle). Optional spurious AdvancePC pulses.
    task automatic fetch(input int gd, input int rd, input logic [31:0] d, input bit spur);
        exp_t e;
        e.pc  = m_pc;
        e.ins = d;
        exp_q.push_back(e);
        chk("req_hi", {63'd0, IMemReq}, 64'd1);
        chk("addr", IMemAddr, m_pc);
        for (int i = 0; i < gd; i++) begin
            IMemGnt    = 1'b0;
            IMemRdData = $urandom;
            if (spur) begin
                AdvancePC = 1'b1;
                NextPC    = 64'h2000 + 64'(i);
            end
            step();
            AdvancePC = 1'b0;
            chk("addr_stable", IMemAddr, m_pc);
            chk("req_held", {63'd0, IMemReq}, 64'd1);
        end
        if (rd == 0) begin
            IMemGnt = 1'b1; IMemRdValid = 1'b1; IMemRdData = d;
            step();
            IMemGnt = 1'b0; IMemRdValid = 1'b0;
        end else begin
            IMemGnt = 1'b1;
            step();
            IMemGnt = 1'b0;
            chk("req_lo_wait", {63'd0, IMemReq}, 64'd0);
            for (int i = 0; i < rd - 1; i++) begin
                if (spur) begin
                    AdvancePC = 1'b1;
                    NextPC    = 64'h3000;
                end
                step();
                AdvancePC = 1'b0;
                chk("ivld_wait", {63'd0, InstrValid}, 64'd0);
            end
            IMemRdValid = 1'b1; IMemRdData = d;
            step();
            IMemRdValid = 1'b0;
        end
        chk("ivld", {63'd0, InstrValid}, 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr", {32'd0, Instruction}, {32'd0, e.ins});
            chk("pc_hold", CurrentPC, e.pc);
            last_ins = e.ins;
        end
        chk("cnt_unchg", {32'd0, RetireCount}, 64'(m_cnt));
    endtask

    task automatic advance(input logic [63:0] npc);
        AdvancePC = 1'b1;
        NextPC    = npc;
        step();
        AdvancePC = 1'b0;
        m_cnt++;
        if (npc[1:0] == 2'b00) begin
            m_pc = npc;
            chk("adv_req", {63'd0, IMemReq}, 64'd1);
            chk("adv_fault", {63'd0, FetchFault}, 64'd0);
        end else begin
            chk("flt_set", {63'd0, FetchFault}, 64'd1);
            chk("flt_req", {63'd0, IMemReq}, 64'd0);
        end
        chk("adv_pc", CurrentPC, m_pc);
        chk("adv_ivld", {63'd0, InstrValid}, 64'd0);
        chk("adv_cnt", {32'd0, RetireCount}, 64'(m_cnt));
        chk("adv_cnt4", {60'd0, cnt4}, 64'(m_cnt % 16));
    endtask

    initial begin
        Reset = 1'b1; NextPC = '0; AdvancePC = 1'b0;
        IMemGnt = 1'b0; IMemRdValid = 1'b0; IMemRdData = '0;
        m_pc = 64'h0; m_cnt = 0; last_ins = '0;
        repeat (2) step();
        chk("rst_pc", CurrentPC, 64'h0);
        chk("rst_req", {63'd0, IMemReq}, 64'd0);
        chk("rst_ivld", {63'd0, InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, Instruction}, 64'd0);
        chk("rst_fault", {63'd0, FetchFault}, 64'd0);
        chk("rst_cnt", {32'd0, RetireCount}, 64'd0);

        // Reset release: edge 1 requests address 0, zero-wait memory.
        Reset = 1'b0;
        step();
        chk("e1_ivld", {63'd0, InstrValid}, 64'd0);
        fetch(0, 0, 32'hF84003E9, 1'b0);

        advance(64'h4);
        // Slow memory with spurious advances in REQ and WAIT.
        fetch(3, 2, 32'h12345678, 1'b1);

        // Stale response in HOLD must not overwrite the held instruction.
        IMemRdValid = 1'b1; IMemRdData = 32'hDEADBEEF;
        step();
        IMemRdValid = 1'b0;
        chk("stale_instr", {32'd0, Instruction}, {32'd0, last_ins});
        chk("stale_ivld", {63'd0, InstrValid}, 64'd1);

        for (int k = 0; k < 15; k++) begin
            advance(m_pc + 64'h4);
            fetch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, (k % 3) == 0);
        end
        advance(64'h100);   // 17th retirement: 4-bit counter wraps to 1
        chk("wrap_cnt4", {60'd0, cnt4}, 64'd1);
        fetch(1, 1, 32'hCAFEF00D, 1'b0);

        advance(64'h102);   // misaligned
        for (int i = 0; i < 3; i++) begin
            AdvancePC = 1'b1; NextPC = 64'h8; IMemGnt = 1'b1; IMemRdValid = 1'b1;
            step();
            chk("flt_sticky", {63'd0, FetchFault}, 64'd1);
            chk("flt_req_lo", {63'd0, IMemReq}, 64'd0);
            chk("flt_ivld_lo", {63'd0, InstrValid}, 64'd0);
            chk("flt_pc", CurrentPC, m_pc);
            chk("flt_cnt", {32'd0, RetireCount}, 64'(m_cnt));
        end
        AdvancePC = 1'b0; IMemGnt = 1'b0; IMemRdValid = 1'b0;

        // Reset while in WAIT; response arrives during and right after reset.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_pc = 64'h0; m_cnt = 0;
        step();
        IMemGnt = 1'b1;
        step();
        IMemGnt = 1'b0;
        chk("w_req_lo", {63'd0, IMemReq}, 64'd0);
        #1 Reset = 1'b1;
        #1;
        chk("ar_pc", CurrentPC, 64'h0);
        chk("ar_req", {63'd0, IMemReq}, 64'd0);
        chk("ar_ivld", {63'd0, InstrValid}, 64'd0);
        chk("ar_fault", {63'd0, FetchFault}, 64'd0);
        chk("ar_cnt", {32'd0, RetireCount}, 64'd0);
        IMemRdValid = 1'b1; IMemRdData = 32'hAAAA5555;
        step();
        Reset = 1'b0;
        step();
        IMemRdValid = 1'b0;
        chk("post_ivld", {63'd0, InstrValid}, 64'd0);
        chk("post_instr", {32'd0, Instruction}, 64'd0);
        chk("post_req", {63'd0, IMemReq}, 64'd1);
        chk("post_pc", CurrentPC, 64'h0);
        fetch(0, 1, 32'h0BADC0DE, 1'b0);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
